// File: rtl/restoring_divider_seq.sv
// Sequential unsigned restoring divider: one quotient bit per enabled clock,
// with valid/ready handshakes on both the operand and the result side.
module restoring_divider_seq #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             res_vld,
    input  logic             res_rdy,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int cw = (width > 2) ? $clog2(width) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [cw-1:0]    count;
    logic [width-1:0] partial_rem;
    logic [width-1:0] shift_reg;
    logic [width-1:0] divisor_reg;

    logic [width:0]   shifted;
    logic [width:0]   trial;
    logic [width-1:0] rem_next;
    logic [width-1:0] quo_next;

    assign in_rdy = (state == IDLE);
    assign busy   = (state != IDLE);

    // Trial subtraction is one bit wider than the operands so the borrow survives.
    always_comb begin
        shifted = {partial_rem, shift_reg[width-1]};
        trial   = shifted - {1'b0, divisor_reg};
        if (!trial[width]) begin
            rem_next = trial[width-1:0];
            quo_next = {shift_reg[width-2:0], 1'b1};
        end else begin
            rem_next = shifted[width-1:0];
            quo_next = {shift_reg[width-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            partial_rem <= '0;
            shift_reg   <= '0;
            divisor_reg <= '0;
            res_vld     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (in_vld) begin
                        divisor_reg <= divisor;
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            res_vld     <= 1'b1;
                        end else begin
                            state       <= RUN;
                            partial_rem <= '0;
                            shift_reg   <= dividend;
                            count       <= cw'(width - 1);
                        end
                    end
                end
                RUN: begin
                    partial_rem <= rem_next;
                    shift_reg   <= quo_next;
                    if (count == '0) begin
                        // Final iteration: publish the result on the same edge.
                        state       <= DONE;
                        quotient    <= quo_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        res_vld     <= 1'b1;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    if (res_rdy) begin
                        state   <= IDLE;
                        res_vld <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    res_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule
